// File: rtl/rob_param.sv
// Parametrised in-order reorder buffer: tagged allocation, multi-channel writeback,
// bypassed two-source operand lookup, single in-order retire and flush on taken redirect.
module rob_param #(
   parameter int DEPTH  = 7,
   parameter int TAG_W  = 3,
   parameter int NUM_WB = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alloc_valid,
   input  logic [1:0]               alloc_kind,
   input  logic [4:0]               alloc_rd,
   input  logic [31:0]              alloc_value,
   input  logic [31:0]              alloc_pc,
   output logic                     alloc_ready,
   output logic [TAG_W-1:0]         alloc_tag,
   input  logic [NUM_WB-1:0]        wb_valid,
   input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
   input  logic [NUM_WB*32-1:0]     wb_value,
   input  logic [TAG_W-1:0]         src1_tag,
   input  logic [TAG_W-1:0]         src2_tag,
   output logic                     src1_hit,
   output logic                     src2_hit,
   output logic [31:0]              src1_value,
   output logic [31:0]              src2_value,
   output logic                     commit_valid,
   output logic [4:0]               commit_rd,
   output logic [TAG_W-1:0]         commit_tag,
   output logic [31:0]              commit_value,
   output logic                     redirect_valid,
   output logic [31:0]              redirect_pc,
   output logic [TAG_W:0]           count
);

   localparam int         NENT   = 1 << TAG_W;
   localparam logic [1:0] K_NORM = 2'd0;
   localparam logic [1:0] K_BR   = 2'd1;
   localparam logic [1:0] K_JALR = 2'd2;
   localparam logic [1:0] K_PRE  = 2'd3;

   // Storage is indexed directly by tag; slot 0 and slots above DEPTH stay invalid.
   logic        r_valid  [NENT];
   logic        r_done   [NENT];
   logic [1:0]  r_kind   [NENT];
   logic [4:0]  r_rd     [NENT];
   logic [31:0] r_value  [NENT];
   logic [31:0] r_target [NENT];

   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;

   logic             w_alloc;
   logic             w_commit;
   logic             w_redirect;
   logic [TAG_W:0]   w_count_nxt;
   logic [32:0]      w_lk1;
   logic [32:0]      w_lk2;

   function automatic logic [TAG_W-1:0] f_next(input logic [TAG_W-1:0] p);
      return (p == TAG_W'(DEPTH)) ? TAG_W'(1) : p + TAG_W'(1);
   endfunction

   // Returns {hit, value}; branch entries never forward since their value is only a taken flag.
   function automatic logic [32:0] f_lookup(input logic [TAG_W-1:0] t);
      logic [32:0] res;
      res = '0;
      if (t != '0 && r_valid[t] && r_kind[t] != K_BR) begin
         if (r_done[t]) begin
            res = {1'b1, r_value[t]};
         end else begin
            for (int k = 0; k < NUM_WB; k++) begin
               if (wb_valid[k] && wb_tag[k*TAG_W +: TAG_W] == t)
                  res = {1'b1, wb_value[k*32 +: 32]};
            end
         end
      end
      return res;
   endfunction

   always_comb begin
      w_alloc     = alloc_valid && alloc_ready;
      w_commit    = r_valid[r_head] && r_done[r_head];
      w_redirect  = w_commit && ((r_kind[r_head] == K_BR && r_value[r_head][0]) ||
                                  r_kind[r_head] == K_JALR);
      w_count_nxt = count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_commit);
      w_lk1       = f_lookup(src1_tag);
      w_lk2       = f_lookup(src2_tag);
      src1_hit    = w_lk1[32];
      src1_value  = w_lk1[31:0];
      src2_hit    = w_lk2[32];
      src2_value  = w_lk2[31:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int e = 0; e < NENT; e++) begin
            r_valid[e] <= 1'b0;
            r_done[e]  <= 1'b0;
         end
         r_head         <= TAG_W'(1);
         r_tail         <= TAG_W'(1);
         count          <= '0;
         alloc_ready    <= 1'b1;
         alloc_tag      <= TAG_W'(1);
         commit_valid   <= 1'b0;
         commit_rd      <= '0;
         commit_tag     <= '0;
         commit_value   <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         commit_valid   <= w_commit;
         commit_tag     <= w_commit ? r_head : '0;
         commit_rd      <= (w_commit && r_kind[r_head] != K_BR) ? r_rd[r_head] : '0;
         commit_value   <= w_commit ? r_value[r_head] : '0;
         redirect_valid <= w_redirect;
         redirect_pc    <= w_redirect ? r_target[r_head] : '0;

         if (w_redirect) begin
            // Retiring a redirect squashes everything younger, including this cycle's alloc/wb.
            for (int e = 0; e < NENT; e++) begin
               r_valid[e] <= 1'b0;
               r_done[e]  <= 1'b0;
            end
            r_head      <= TAG_W'(1);
            r_tail      <= TAG_W'(1);
            count       <= '0;
            alloc_ready <= 1'b1;
            alloc_tag   <= TAG_W'(1);
         end else begin
            // Later channels overwrite earlier ones, so the highest index wins on a tag clash.
            for (int e = 1; e < NENT; e++) begin
               for (int k = 0; k < NUM_WB; k++) begin
                  if (wb_valid[k] && wb_tag[k*TAG_W +: TAG_W] == TAG_W'(e) &&
                      r_valid[e] && !r_done[e]) begin
                     case (r_kind[e])
                        K_NORM: begin
                           r_value[e] <= wb_value[k*32 +: 32];
                           r_done[e]  <= 1'b1;
                        end
                        K_BR: begin
                           r_value[e] <= {31'd0, |wb_value[k*32 +: 32]};
                           r_done[e]  <= 1'b1;
                        end
                        K_JALR: begin
                           r_target[e] <= wb_value[k*32 +: 32] & ~32'd1;
                           r_done[e]   <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
            end

            if (w_commit) begin
               r_valid[r_head] <= 1'b0;
               r_done[r_head]  <= 1'b0;
               r_head          <= f_next(r_head);
            end

            if (w_alloc) begin
               r_valid[r_tail]  <= 1'b1;
               r_done[r_tail]   <= (alloc_kind == K_PRE);
               r_kind[r_tail]   <= alloc_kind;
               r_rd[r_tail]     <= alloc_rd;
               r_value[r_tail]  <= (alloc_kind == K_BR) ? 32'd0 : alloc_value;
               r_target[r_tail] <= alloc_pc + alloc_value;
               r_tail           <= f_next(r_tail);
            end

            count       <= w_count_nxt;
            alloc_ready <= (w_count_nxt < (TAG_W+1)'(DEPTH));
            alloc_tag   <= w_alloc ? f_next(r_tail) : r_tail;
         end
      end
   end

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param: fill/full, out-of-order writeback, bypass lookup,
// taken-branch flush, tag wrap-around and mid-operation reset.
module tb_rob_param;
   logic        clk;
   logic        rst;
   logic        alloc_valid;
   logic [1:0]  alloc_kind;
   logic [4:0]  alloc_rd;
   logic [31:0] alloc_value;
   logic [31:0] alloc_pc;
   logic        alloc_ready;
   logic [2:0]  alloc_tag;
   logic [1:0]  wb_valid;
   logic [5:0]  wb_tag;
   logic [63:0] wb_value;
   logic [2:0]  src1_tag, src2_tag;
   logic        src1_hit, src2_hit;
   logic [31:0] src1_value, src2_value;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [2:0]  commit_tag;
   logic [31:0] commit_value;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [3:0]  count;

   int n_checks = 0;
   int n_err    = 0;

   rob_param #(.DEPTH(7), .TAG_W(3), .NUM_WB(2)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
      .alloc_value(alloc_value), .alloc_pc(alloc_pc),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
      .src1_tag(src1_tag), .src2_tag(src2_tag),
      .src1_hit(src1_hit), .src2_hit(src2_hit),
      .src1_value(src1_value), .src2_value(src2_value),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
      .commit_value(commit_value),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic clear_in();
      alloc_valid = 1'b0; alloc_kind = 2'd0; alloc_rd = 5'd0;
      alloc_value = 32'd0; alloc_pc = 32'd0;
      wb_valid = 2'b00; wb_tag = 6'd0; wb_value = 64'd0;
   endtask

   task automatic set_wb(input int ch, input logic [2:0] tag, input logic [31:0] val);
      wb_valid[ch]         = 1'b1;
      wb_tag[ch*3 +: 3]    = tag;
      wb_value[ch*32 +: 32] = val;
   endtask

   task automatic alloc_one(input logic [1:0] kind, input logic [4:0] rd,
                            input logic [31:0] val, input logic [31:0] pc);
      alloc_valid = 1'b1; alloc_kind = kind; alloc_rd = rd;
      alloc_value = val; alloc_pc = pc;
      @(negedge clk);
      alloc_valid = 1'b0;
   endtask

   task automatic expect_commit(input logic [2:0] tag, input logic [31:0] val);
      int n;
      n = 0;
      while (!commit_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("commit_seen", 32'(commit_valid), 32'd1);
      chk("commit_tag", 32'(commit_tag), 32'(tag));
      chk("commit_value", commit_value, val);
      @(negedge clk);
   endtask

   initial begin
      clear_in();
      src1_tag = 3'd0; src2_tag = 3'd0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(alloc_ready), 32'd1);
      chk("rst_tag", 32'(alloc_tag), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_commit", 32'(commit_valid), 32'd0);
      chk("rst_redirect", 32'(redirect_valid), 32'd0);

      // Fill with 7 normal ops, then an 8th that must be dropped.
      for (int i = 1; i <= 7; i++) begin
         chk("fill_tag", 32'(alloc_tag), 32'(i));
         chk("fill_ready", 32'(alloc_ready), 32'd1);
         alloc_one(2'd0, 5'(i), 32'd0, 32'h1000 + 32'(4*i));
      end
      chk("full_ready", 32'(alloc_ready), 32'd0);
      chk("full_count", 32'(count), 32'd7);
      alloc_one(2'd0, 5'd9, 32'd0, 32'h2000);
      chk("drop_count", 32'(count), 32'd7);
      chk("drop_tag", 32'(alloc_tag), 32'd1);

      // Out-of-order writeback; retire in order.
      set_wb(0, 3'd2, 32'h22);
      set_wb(1, 3'd1, 32'h11);
      @(negedge clk);
      clear_in();
      chk("ooo_nocommit", 32'(commit_valid), 32'd0);
      @(negedge clk);
      chk("ooo_c1_valid", 32'(commit_valid), 32'd1);
      chk("ooo_c1_tag", 32'(commit_tag), 32'd1);
      chk("ooo_c1_value", commit_value, 32'h11);
      chk("ooo_c1_rd", 32'(commit_rd), 32'd1);
      @(negedge clk);
      chk("ooo_c2_tag", 32'(commit_tag), 32'd2);
      chk("ooo_c2_value", commit_value, 32'h22);
      chk("ooo_count", 32'(count), 32'd5);
      @(negedge clk);
      chk("ooo_idle", 32'(commit_valid), 32'd0);

      // Same-cycle bypass lookup.
      src1_tag = 3'd3; src2_tag = 3'd0;
      set_wb(1, 3'd3, 32'hABCD);
      #1;
      chk("byp_hit1", 32'(src1_hit), 32'd1);
      chk("byp_val1", src1_value, 32'hABCD);
      chk("byp_hit2", 32'(src2_hit), 32'd0);
      chk("byp_val2", src2_value, 32'd0);
      @(negedge clk);
      clear_in();
      #1;
      chk("done_hit1", 32'(src1_hit), 32'd1);
      chk("done_val1", src1_value, 32'hABCD);
      @(negedge clk);
      chk("c3_tag", 32'(commit_tag), 32'd3);
      chk("c3_value", commit_value, 32'hABCD);
      chk("c3_count", 32'(count), 32'd4);
      src1_tag = 3'd0;

      // Build up 5 entries with 2 done, then reset mid-operation.
      alloc_valid = 1'b1; alloc_kind = 2'd3; alloc_rd = 5'd9; alloc_value = 32'h77;
      set_wb(0, 3'd5, 32'h55);
      @(negedge clk);
      clear_in();
      chk("pre_rst_count", 32'(count), 32'd5);
      chk("pre_rst_commit", 32'(commit_valid), 32'd0);
      chk("pre_rst_tag", 32'(alloc_tag), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_commit", 32'(commit_valid), 32'd0);
      chk("mid_rst_tag", 32'(alloc_tag), 32'd1);
      chk("mid_rst_ready", 32'(alloc_ready), 32'd1);

      // Taken branch at tag 1 flushes younger entries and a concurrent alloc/wb.
      alloc_one(2'd1, 5'd7, 32'h40, 32'h100);
      for (int i = 2; i <= 4; i++) alloc_one(2'd0, 5'(i), 32'd0, 32'h200);
      set_wb(0, 3'd1, 32'd1);
      @(negedge clk);
      clear_in();
      chk("br_nocommit", 32'(commit_valid), 32'd0);
      src1_tag = 3'd1;
      #1;
      chk("br_lookup_hit", 32'(src1_hit), 32'd0);
      src1_tag = 3'd0;
      alloc_valid = 1'b1; alloc_kind = 2'd0; alloc_rd = 5'd3;
      set_wb(0, 3'd2, 32'h55);
      @(negedge clk);
      clear_in();
      chk("br_commit", 32'(commit_valid), 32'd1);
      chk("br_tag", 32'(commit_tag), 32'd1);
      chk("br_rd", 32'(commit_rd), 32'd0);
      chk("br_redirect", 32'(redirect_valid), 32'd1);
      chk("br_pc", redirect_pc, 32'h140);
      chk("br_count", 32'(count), 32'd0);
      chk("br_next_tag", 32'(alloc_tag), 32'd1);
      @(negedge clk);
      chk("br_after_commit", 32'(commit_valid), 32'd0);
      chk("br_after_redirect", 32'(redirect_valid), 32'd0);
      chk("br_after_count", 32'(count), 32'd0);

      // Wrap-around: fill, retire 3, allocate 3 more with tags 1..3.
      for (int i = 1; i <= 7; i++) alloc_one(2'd0, 5'(i), 32'd0, 32'h300);
      set_wb(0, 3'd1, 32'h101);
      set_wb(1, 3'd2, 32'h102);
      @(negedge clk);
      clear_in();
      set_wb(0, 3'd3, 32'h103);
      @(negedge clk);
      clear_in();
      expect_commit(3'd1, 32'h101);
      expect_commit(3'd2, 32'h102);
      expect_commit(3'd3, 32'h103);
      chk("wrap_count", 32'(count), 32'd4);
      for (int i = 1; i <= 3; i++) begin
         chk("wrap_tag", 32'(alloc_tag), 32'(i));
         alloc_one(2'd3, 5'(10 + i), 32'hA0 + 32'(i), 32'h400);
      end
      chk("wrap_full_ready", 32'(alloc_ready), 32'd0);
      chk("wrap_full_tag", 32'(alloc_tag), 32'd4);
      set_wb(0, 3'd7, 32'h107);
      @(negedge clk);
      clear_in();
      set_wb(0, 3'd6, 32'hDEAD);
      set_wb(1, 3'd6, 32'h106);
      src1_tag = 3'd6;
      #1;
      chk("clash_bypass", src1_value, 32'h106);
      @(negedge clk);
      clear_in();
      src1_tag = 3'd0;
      set_wb(0, 3'd4, 32'h104);
      set_wb(1, 3'd5, 32'h105);
      @(negedge clk);
      clear_in();
      expect_commit(3'd4, 32'h104);
      expect_commit(3'd5, 32'h105);
      expect_commit(3'd6, 32'h106);
      expect_commit(3'd7, 32'h107);
      expect_commit(3'd1, 32'hA1);
      expect_commit(3'd2, 32'hA2);
      expect_commit(3'd3, 32'hA3);
      chk("wrap_end_count", 32'(count), 32'd0);
      chk("wrap_end_commit", 32'(commit_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
